// File: rtl/uart_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_drain_ctrl
//  Description : Drains the UART receive FIFO, packs bytes little-endian into
//                32-bit words and writes them to a circular buffer in memory
//                through a valid/ready write port. A partially filled word is
//                flushed after a programmable idle timeout or when the drain
//                is disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_drain_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  len_words_i,
    input  logic [15:0]       timeout_i,
    input  logic              rx_fifo_empty_i,
    input  logic [7:0]        rx_fifo_data_i,
    output logic              rx_fifo_read_o,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_be_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic              wrap_o,
    output logic              busy_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;       // byte address of the word being built
    logic [CNT_W-1:0]  r_ring_idx;   // word slot within the ring
    logic [CNT_W-1:0]  r_word_cnt;   // words written since enable
    logic [1:0]        r_byte_idx;   // next byte lane to fill
    logic [15:0]       r_idle_cnt;   // empty-FIFO clocks since the last pop
    logic [31:0]       r_pack;       // word under construction
    logic [3:0]        r_be;         // lanes already filled
    logic              r_wrap;       // one-cycle wrap indication

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_base_al;
    logic [CNT_W-1:0]  w_last_idx;
    logic              w_pop;
    logic              w_hs;
    logic              w_ring_end;
    logic              w_timeout_hit;
    logic              w_cnt_max;
    logic              w_unused_base;

    // The ring base is always treated as word aligned.
    assign w_base_al     = {base_addr_i[ADDR_W-1:2], 2'b00};
    assign w_unused_base = ^base_addr_i[1:0];

    // A zero length behaves as a one-word ring.
    assign w_last_idx = (len_words_i == '0) ? '0 : (len_words_i - CNT_W'(1));

    // Bytes are only taken while filling and enabled; the FIFO is
    // first-word-fall-through so the head byte is captured on this edge.
    assign w_pop = (r_state == c_FILL) && !rx_fifo_empty_i && en_i;

    // Write handshake: request is held until accepted.
    assign w_hs = (r_state == c_WRITE) && wr_ready_i;

    // Length is sampled live; a ring shortened below the current slot wraps
    // on the next write rather than running on until the index rolls over.
    assign w_ring_end = (r_ring_idx >= w_last_idx);

    // Compare against the pre-increment count so that a timeout of N yields
    // the flush after exactly N idle clocks.
    assign w_timeout_hit = (timeout_i != 16'd0) &&
                           (r_idle_cnt == (timeout_i - 16'd1));

    assign w_cnt_max = &r_word_cnt;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_fifo_read_o = w_pop;
    assign wr_valid_o     = (r_state == c_WRITE);
    assign wr_addr_o      = r_addr;
    assign wr_data_o      = r_pack;
    assign wr_be_o        = r_be;
    assign word_cnt_o     = r_word_cnt;
    assign wrap_o         = r_wrap;
    assign busy_o         = (r_state != c_IDLE);

    // Next-state decode for the drain sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (en_i) begin
                    w_state_nxt = c_FILL;
                end
            end
            c_FILL: begin
                if (!en_i) begin
                    // Disabling flushes any partial word before going idle.
                    w_state_nxt = (r_byte_idx != 2'd0) ? c_WRITE : c_IDLE;
                end else if (w_pop && (r_byte_idx == 2'd3)) begin
                    w_state_nxt = c_WRITE;
                end else if (rx_fifo_empty_i && (r_byte_idx != 2'd0) && w_timeout_hit) begin
                    w_state_nxt = c_WRITE;
                end
            end
            c_WRITE: begin
                if (wr_ready_i) begin
                    w_state_nxt = en_i ? c_FILL : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte packing, lane enables and idle timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack     <= '0;
            r_be       <= '0;
            r_byte_idx <= '0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (en_i) begin
                        r_pack     <= '0;
                        r_be       <= '0;
                        r_byte_idx <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                c_FILL: begin
                    if (w_pop) begin
                        r_pack[{r_byte_idx, 3'b000} +: 8] <= rx_fifo_data_i;
                        r_be[r_byte_idx]                  <= 1'b1;
                        r_byte_idx                        <= r_byte_idx + 2'd1;
                        r_idle_cnt                        <= '0;
                    end else if (en_i && (r_byte_idx != 2'd0)) begin
                        // Only a partially built word ages toward a flush.
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end
                c_WRITE: begin
                    if (wr_ready_i) begin
                        r_pack     <= '0;
                        r_be       <= '0;
                        r_byte_idx <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                default: begin
                    r_pack     <= '0;
                    r_be       <= '0;
                    r_byte_idx <= '0;
                    r_idle_cnt <= '0;
                end
            endcase
        end
    end

    // Ring address, slot index, word counter and wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_ring_idx <= '0;
            r_word_cnt <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if ((r_state == c_IDLE) && en_i) begin
                r_addr     <= w_base_al;
                r_ring_idx <= '0;
                r_word_cnt <= '0;
            end else if (w_hs) begin
                if (!w_cnt_max) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
                if (w_ring_end) begin
                    r_addr     <= w_base_al;
                    r_ring_idx <= '0;
                    r_wrap     <= 1'b1;
                end else begin
                    r_addr     <= r_addr + ADDR_W'(4);
                    r_ring_idx <= r_ring_idx + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_drain_ctrl
//  Description : Self-checking bench for uart_rx_drain_ctrl. Bytes go through
//                a bench-side FIFO; the expected write stream is a list of
//                words built from the pushed bytes and known flush points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] len_words_i = '0;
    logic [15:0] timeout_i = '0;
    logic        rx_fifo_empty_i;
    logic [7:0]  rx_fifo_data_i;
    logic        rx_fifo_read_o;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b0;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_be_o;
    logic [15:0] word_cnt_o;
    logic        wrap_o;
    logic        busy_o;

    uart_rx_drain_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_i            (en_i),
        .base_addr_i     (base_addr_i),
        .len_words_i     (len_words_i),
        .timeout_i       (timeout_i),
        .rx_fifo_empty_i (rx_fifo_empty_i),
        .rx_fifo_data_i  (rx_fifo_data_i),
        .rx_fifo_read_o  (rx_fifo_read_o),
        .wr_valid_o      (wr_valid_o),
        .wr_ready_i      (wr_ready_i),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o),
        .wr_be_o         (wr_be_o),
        .word_cnt_o      (word_cnt_o),
        .wrap_o          (wrap_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    // ---------------- bench FIFO (first-word-fall-through) ----------------
    logic [7:0]  fifo_mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign rx_fifo_empty_i = (wr_ptr == rd_ptr);
    assign rx_fifo_data_i  = fifo_mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (rx_fifo_read_o && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 1;
    end

    // ---------------- write-port ready driver ----------------
    logic rdy_rand  = 1'b0;
    logic rdy_force = 1'b1;
    always @(negedge clk) begin
        wr_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          obs_n = 0;
    logic [31:0] obs_addr [0:255];
    logic [31:0] obs_data [0:255];
    logic [3:0]  obs_be   [0:255];
    int          obs_cyc  [0:255];
    int          wrap_at  [0:255];
    int          wrap_n = 0;
    int          proto_err = 0;
    int          last_pop_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;
    logic [3:0]  p_be = '0;

    always begin
        @(negedge clk);
        #3;
        cyc = cyc + 1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(wr_valid_o && wr_addr_o == p_addr &&
                                wr_data_o == p_data && wr_be_o == p_be))
                proto_err = proto_err + 1;
            if (wr_valid_o && rx_fifo_read_o) proto_err = proto_err + 1;
            if (rx_fifo_read_o && rx_fifo_empty_i) proto_err = proto_err + 1;
            if (rx_fifo_read_o) last_pop_cyc = cyc;
            if (wrap_o && wrap_n < 256) begin
                wrap_at[wrap_n] = obs_n;
                wrap_n = wrap_n + 1;
            end
            if (wr_valid_o && wr_ready_i && obs_n < 256) begin
                obs_addr[obs_n] = wr_addr_o;
                obs_data[obs_n] = wr_data_o;
                obs_be[obs_n]   = wr_be_o;
                obs_cyc[obs_n]  = cyc;
                obs_n = obs_n + 1;
            end
            prev_stall = wr_valid_o && !wr_ready_i;
            p_addr = wr_addr_o;
            p_data = wr_data_o;
            p_be   = wr_be_o;
        end
    end

    // ---------------- reference model and checking ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_data [$];
    logic [3:0]  exp_be   [$];
    logic [31:0] cur_word = '0;
    int          cur_k = 0;
    logic [31:0] run_base = '0;
    int          run_len = 0;
    int          s = 0;
    int          ws = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic close_word();
        if (cur_k != 0) begin
            exp_data.push_back(cur_word);
            exp_be.push_back(4'((1 << cur_k) - 1));
            cur_word = '0;
            cur_k = 0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
        cur_word[8*cur_k +: 8] = b;
        cur_k++;
        if (cur_k == 4) close_word();
    endtask

    task automatic begin_run(input logic [31:0] b, input logic [15:0] l, input logic [15:0] t);
        base_addr_i = b;
        len_words_i = l;
        timeout_i   = t;
        run_base = b;
        run_len  = int'(l);
        exp_data.delete();
        exp_be.delete();
        cur_word = '0;
        cur_k = 0;
        s  = obs_n;
        ws = wrap_n;
        en_i = 1'b1;
        tick(1);
    endtask

    task automatic check_model(input string tag);
        int          n;
        int          leff;
        int          nw;
        logic [31:0] base_al;
        n = exp_data.size();
        leff = (run_len == 0) ? 1 : run_len;
        base_al = run_base & 32'hFFFF_FFFC;
        chk({tag, "_count"}, obs_n - s, n);
        for (int i = 0; i < n && (s + i) < 256; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), obs_addr[s+i], base_al + 32'(4 * (i % leff)));
            chk($sformatf("%s_data%0d", tag, i), obs_data[s+i], exp_data[i]);
            chk($sformatf("%s_be%0d", tag, i), obs_be[s+i], exp_be[i]);
        end
        nw = n / leff;
        chk({tag, "_wraps"}, wrap_n - ws, nw);
        for (int j = 0; j < nw && (ws + j) < 256; j++)
            chk($sformatf("%s_wrapat%0d", tag, j), wrap_at[ws+j], s + (j + 1) * leff);
        chk({tag, "_wcnt"}, word_cnt_o, n);
        chk({tag, "_proto"}, proto_err, 0);
    endtask

    task automatic finish_run(input string tag);
        int budget;
        budget = 0;
        while (wr_ptr != rd_ptr && budget < 2000) begin
            tick(1);
            budget++;
        end
        chk({tag, "_drained"}, (wr_ptr == rd_ptr), 1);
        tick(1);
        en_i = 1'b0;
        close_word();
        budget = 0;
        while (busy_o && budget < 2000) begin
            tick(1);
            budget++;
        end
        chk({tag, "_idle"}, busy_o, 0);
        tick(2);
        check_model(tag);
    endtask

    initial begin
        int budget;
        int nb;
        int tmo;

        // ---- reset state ----
        tick(3);
        chk("rst_valid", wr_valid_o, 0);
        chk("rst_read", rx_fifo_read_o, 0);
        chk("rst_addr", wr_addr_o, 0);
        chk("rst_data", wr_data_o, 0);
        chk("rst_be", wr_be_o, 0);
        chk("rst_wcnt", word_cnt_o, 0);
        chk("rst_wrap", wrap_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", busy_o, 0);

        // ---- single full word ----
        rdy_rand = 1'b0; rdy_force = 1'b1;
        begin_run(32'h100, 16'd4, 16'd0);
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        finish_run("one_word");
        chk("one_word_const", obs_data[s], 32'hA3A2A1A0);

        // ---- 16 bytes, ring of 4, random back-pressure ----
        rdy_rand = 1'b1;
        begin_run(32'h100, 16'd4, 16'd0);
        for (int i = 0; i < 16; i++) push(8'($urandom));
        finish_run("ring4");
        chk("ring4_addr_back", wr_addr_o, 32'h100);

        // ---- idle timeout flush, then timeout disabled, then disable flush ----
        rdy_rand = 1'b0; rdy_force = 1'b1;
        begin_run(32'h300, 16'd4, 16'd10);
        push(8'($urandom)); push(8'($urandom));
        close_word();
        tick(30);
        chk("tmo_count", obs_n - s, 1);
        chk("tmo_gap", obs_cyc[s] - last_pop_cyc, 11);
        timeout_i = 16'd0;
        push(8'($urandom));
        tick(60);
        chk("notmo_count", obs_n - s, 1);
        chk("notmo_busy", busy_o, 1);
        finish_run("tmo");
        chk("dis_busy", busy_o, 0);

        // ---- random timeouts ----
        for (int r = 0; r < 3; r++) begin
            tmo = $urandom_range(1, 12);
            nb  = $urandom_range(1, 3);
            begin_run($urandom, 16'($urandom_range(1, 3)), 16'(tmo));
            for (int i = 0; i < nb; i++) push(8'($urandom));
            close_word();
            tick(tmo + 8);
            chk($sformatf("rtmo%0d_gap", r), obs_cyc[s] - last_pop_cyc, tmo + 1);
            finish_run($sformatf("rtmo%0d", r));
        end

        // ---- back-pressure hold ----
        rdy_rand = 1'b0; rdy_force = 1'b0;
        begin_run(32'h600, 16'd8, 16'd0);
        for (int i = 0; i < 6; i++) push(8'($urandom));
        tick(24);
        chk("bp_valid", wr_valid_o, 1);
        chk("bp_noread", rx_fifo_read_o, 0);
        chk("bp_left", wr_ptr - rd_ptr, 2);
        chk("bp_nowrite", obs_n - s, 0);
        chk("bp_addr", wr_addr_o, 32'h600);
        chk("bp_data", wr_data_o, exp_data[0]);
        chk("bp_proto", proto_err, 0);
        rdy_force = 1'b1;
        tick(3);
        chk("bp_release", obs_n - s, 1);
        finish_run("bp");

        // ---- random streams: random base (low bits ignored), length 0..5 ----
        rdy_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            begin_run($urandom, 16'($urandom_range(0, 5)), 16'd0);
            nb = $urandom_range(1, 40);
            for (int i = 0; i < nb; i++) begin
                push(8'($urandom));
                tick($urandom_range(0, 3));
            end
            finish_run($sformatf("rnd%0d", r));
        end

        // ---- reset during a pending write ----
        rdy_rand = 1'b0; rdy_force = 1'b0;
        begin_run(32'h700, 16'd2, 16'd0);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        budget = 0;
        while (!wr_valid_o && budget < 20) begin
            tick(1);
            budget++;
        end
        chk("mrst_pending", wr_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", wr_valid_o, 0);
        chk("mrst_read", rx_fifo_read_o, 0);
        chk("mrst_addr", wr_addr_o, 0);
        chk("mrst_data", wr_data_o, 0);
        chk("mrst_be", wr_be_o, 0);
        chk("mrst_wcnt", word_cnt_o, 0);
        chk("mrst_busy", busy_o, 0);
        tick(1);
        en_i = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        rdy_rand = 1'b1;
        begin_run(32'h800, 16'd3, 16'd0);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        finish_run("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
